// File: rtl/dmem_copy_pkg.sv
// Shared types and constants for the data-memory copy engine.
package dmem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/copy_stage_buf.sv
// Staging register file for the copy engine: filled in order during READ,
// drained in order during WRITE, with combinational read at the drain index.
module copy_stage_buf #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic          clear,
  output logic [CW-1:0] fill,
  output logic [CW-1:0] drain,
  output logic [31:0]   rd_data
);

  logic [31:0] words [DEPTH];

  // NOTE: the word storage has no reset; its contents are always written before being read.
  always_ff @(posedge clk) begin
    if (wr_en) words[fill[CW-2:0]] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill  <= '0;
      drain <= '0;
    end else if (clear) begin
      fill  <= '0;
      drain <= '0;
    end else begin
      if (wr_en) fill  <= fill + CW'(1);
      if (rd_en) drain <= drain + CW'(1);
    end
  end

  assign rd_data = words[drain[CW-2:0]];

endmodule

// File: rtl/dmem_copy_engine.sv
// DMA-style word copier on the data-memory port: bursts of up to BUF_DEPTH reads, then writes.
// Optional macro CHECKSUM_EN adds a running mod-2^32 sum of all words read.
module dmem_copy_engine
  import dmem_copy_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_dout
`ifdef CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  state_t           state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [LEN_W-1:0] remaining;
  logic             err_flag;
  logic [CW-1:0]    fill;
  logic [CW-1:0]    drain;
  logic [31:0]      buf_rd_data;
  logic             last_read;
  logic             last_write;

  // A burst ends when the buffer is about to fill or the final word is being read.
  assign last_read  = (fill == CW'(BUF_DEPTH - 1)) || (remaining == LEN_W'(1));
  assign last_write = (drain + CW'(1)) == fill;

  copy_stage_buf #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (state == READ),
    .wr_data (mem_dout),
    .rd_en   (state == WRITE),
    .clear   ((state == WRITE) && last_write),
    .fill    (fill),
    .drain   (drain),
    .rd_data (buf_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      err_flag  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= len_words;
            err_flag  <= 1'b0;
            if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
              err_flag <= 1'b1;
              state    <= DONE;
            end else if (len_words == '0) begin
              state <= DONE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          src_ptr   <= src_ptr + 32'(WORD_BYTES);
          remaining <= remaining - LEN_W'(1);
          if (last_read) state <= WRITE;
        end
        WRITE: begin
          dst_ptr <= dst_ptr + 32'(WORD_BYTES);
          if (last_write) state <= (remaining != '0) ? READ : DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port outputs depend only on registered state, never on start.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    if (state == READ) begin
      mem_read = 1'b1;
      mem_addr = src_ptr;
    end else if (state == WRITE) begin
      mem_write = 1'b1;
      mem_addr  = dst_ptr;
      mem_din   = buf_rd_data;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = (state == DONE) && err_flag;

`ifdef CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if (state == READ) begin
      checksum <= checksum + mem_dout;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Scoreboard bench for dmem_copy_engine: a chunked access model predicts every
// memory access, completion cycle, error flag and final destination contents.
module tb_dmem_copy_engine;

  localparam int BUF_DEPTH = 4;
  localparam int LEN_W     = 16;

  typedef struct {
    int unsigned start_cyc;
    int unsigned exp_cycle;
    bit          exp_err;
    logic [31:0] dst;
    int          len;
    logic [31:0] sum;
  } job_t;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len_words;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_din;
  logic             mem_read;
  logic             mem_write;
  logic [31:0]      mem_dout;
`ifdef CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  logic [31:0] mem [0:1023];
  logic        mem_init;
  logic        poke_en;
  logic [9:0]  poke_a;
  logic [31:0] poke_d;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          free_run = 1'b0;
  bit          saw_done = 1'b0;

  job_t        job_q[$];
  acc_t        acc_q[$];
  logic [31:0] word_q[$];

  dmem_copy_engine #(
    .BUF_DEPTH (BUF_DEPTH),
    .LEN_W     (LEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len_words (len_words),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_dout  (mem_dout)
`ifdef CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: asynchronous read, synchronous write.
  assign mem_dout = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= $urandom;
    end else if (poke_en) begin
      mem[poke_a] <= poke_d;
    end
    if (mem_write) mem[mem_addr[11:2]] <= mem_din;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at #1 after a posedge; returns one cycle later.
  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    poke_en = 1'b1;
    poke_a  = addr[11:2];
    poke_d  = data;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, expected 0", busy, k);
    end
    @(posedge clk); #1;
  endtask

  // Reference model: the copy proceeds in chunks of min(BUF_DEPTH, remaining),
  // each chunk being all its reads followed by all its writes.
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n);
    job_t        j;
    acc_t        a;
    int          rem;
    int          chunk;
    logic [31:0] sp;
    logic [31:0] dp;
    logic [31:0] w;
    wait_idle();
    j.exp_err   = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    j.dst       = d;
    j.len       = j.exp_err ? 0 : n;
    j.exp_cycle = (j.exp_err || n == 0) ? 1 : 2 * n + 1;
    j.sum       = '0;
    rem = j.len;
    sp  = s;
    dp  = d;
    while (rem > 0) begin
      chunk = (rem < BUF_DEPTH) ? rem : BUF_DEPTH;
      for (int i = 0; i < chunk; i++) begin
        a.is_write = 1'b0;
        a.addr     = sp + 32'(4 * i);
        a.data     = '0;
        acc_q.push_back(a);
      end
      for (int i = 0; i < chunk; i++) begin
        w = mem[sp[11:2] + 10'(i)];
        a.is_write = 1'b1;
        a.addr     = dp + 32'(4 * i);
        a.data     = w;
        acc_q.push_back(a);
        word_q.push_back(w);
        j.sum += w;
      end
      sp  += 32'(4 * chunk);
      dp  += 32'(4 * chunk);
      rem -= chunk;
    end
    start     = 1'b1;
    src_addr  = s;
    dst_addr  = d;
    len_words = LEN_W'(n);
    @(posedge clk); #1;
    start       = 1'b0;
    j.start_cyc = cyc;
    job_q.push_back(j);
  endtask

  // Monitor: compares every access, idle-bus value, busy level and completion.
  always @(negedge clk) begin : monitor
    job_t j;
    acc_t a;
    if (!reset && free_run) begin
      if (done) saw_done = 1'b1;
    end else if (!reset) begin
      if (mem_read || mem_write) begin
        check("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
        if (acc_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_access: got addr %h write %b, expected no access", mem_addr, mem_write);
        end else begin
          a = acc_q.pop_front();
          check("acc_kind", 32'(mem_write), 32'(a.is_write));
          check("acc_addr", mem_addr, a.addr);
          if (a.is_write) check("acc_data", mem_din, a.data);
        end
      end else begin
        check("idle_addr", mem_addr, 32'd0);
        check("idle_din", mem_din, 32'd0);
      end
      check("busy", 32'(busy), 32'(job_q.size() != 0));
      if (done) begin
        if (job_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_done: got done=1, expected 0");
        end else begin
          j = job_q.pop_front();
          check("done_cycle", cyc - j.start_cyc + 1, j.exp_cycle);
          check("err", 32'(err), 32'(j.exp_err));
          check("accesses_left", acc_q.size(), 32'd0);
          for (int i = 0; i < j.len; i++)
            check("dst_word", mem[j.dst[11:2] + 10'(i)], word_q.pop_front());
`ifdef CHECKSUM_EN
          if (!j.exp_err) check("checksum", checksum, j.sum);
`endif
        end
      end else begin
        check("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] pre1;
    logic [31:0] s;
    logic [31:0] d;
    reset     = 1'b1;
    start     = 1'b0;
    src_addr  = '0;
    dst_addr  = '0;
    len_words = '0;
    poke_en   = 1'b0;
    poke_a    = '0;
    poke_d    = '0;
    mem_init  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
`ifdef CHECKSUM_EN
    check("rst_checksum", checksum, 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic three-word copy, then a multi-burst copy.
    poke(32'h100, 32'h11);
    poke(32'h104, 32'h22);
    poke(32'h108, 32'h33);
    issue(32'h100, 32'h200, 3);
    issue(32'h400, 32'h600, 10);

    // Misaligned source and zero length finish in one cycle without accesses.
    issue(32'h102, 32'h200, 3);
    issue(32'h100, 32'h280, 0);
    issue(32'h100, 32'h283, 2);

    // A start pulse while busy must be ignored.
    issue(32'h500, 32'h700, 6);
    repeat (3) @(posedge clk);
    #1;
    start     = 1'b1;
    src_addr  = 32'h100;
    dst_addr  = 32'h800;
    len_words = LEN_W'(2);
    @(posedge clk); #1;
    start = 1'b0;

    for (int t = 0; t < 10; t++) begin
      s = 32'($urandom_range(0, 255)) << 2;
      d = 32'h800 + (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 5) == 0) s = s | 32'($urandom_range(1, 3));
      issue(s, d, int'($urandom_range(0, 12)));
    end

    // Reset during the second write of a four-word copy.
    wait_idle();
    free_run = 1'b1;
    saw_done = 1'b0;
    poke(32'h300, 32'hA0A0_0001);
    poke(32'h304, 32'hA0A0_0002);
    poke(32'h308, 32'hA0A0_0003);
    poke(32'h30C, 32'hA0A0_0004);
    poke(32'h380, 32'h5555_0000);
    pre1 = 32'h5555_0001;
    poke(32'h384, pre1);
    start     = 1'b1;
    src_addr  = 32'h300;
    dst_addr  = 32'h380;
    len_words = LEN_W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre_reset_write", 32'(mem_write), 32'd1);
    check("pre_reset_addr", mem_addr, 32'h384);
    reset = 1'b1;
    #1;
    check("reset_mem_read", 32'(mem_read), 32'd0);
    check("reset_mem_write", 32'(mem_write), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dst0", mem[10'h380 >> 2], 32'hA0A0_0001);
    check("reset_dst1", mem[10'h384 >> 2], pre1);
    check("reset_no_done", 32'(saw_done), 32'd0);
    free_run = 1'b0;

`ifdef CHECKSUM_EN
    poke(32'h900, 32'hFFFF_FFFF);
    poke(32'h904, 32'h0000_0002);
    issue(32'h900, 32'hA00, 2);
    @(posedge clk); #1;
    start     = 1'b1;
    src_addr  = 32'h100;
    dst_addr  = 32'hB00;
    len_words = LEN_W'(1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("checksum_hold", checksum, 32'h0000_0001);
`endif

    wait_idle();
    check("jobs_left", job_q.size(), 32'd0);
    check("accesses_left_end", acc_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
